// File: rtl/seg_serial_adder_if.sv
// seg_serial_adder_if: handshake/operand bundle for the segmented serial adder.
// Ports (signal names seen from the adder):
//   in_valid_i / in_ready_o   operand handshake
//   input1_i, input2_i        WIDTH-bit operands A and B
//   carry_i                   carry-in to bit 0
//   approx_i                  0 = exact, 1 = approximate (segment carries cut)
//   out_valid_o / out_ready_i result handshake
//   sum_o, carry_o, err_o     WIDTH-bit sum, top carry-out, approx error flag
// The adder connects through the slave modport; the producer/consumer uses master.
interface seg_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] input1_i;
    logic [WIDTH-1:0] input2_i;
    logic             carry_i;
    logic             approx_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             err_o;

    modport slave (
        input  in_valid_i, input1_i, input2_i, carry_i, approx_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, carry_o, err_o
    );

    modport master (
        output in_valid_i, input1_i, input2_i, carry_i, approx_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, carry_o, err_o
    );
endinterface

// File: rtl/seg_serial_adder.sv
// seg_serial_adder: multi-cycle WIDTH-bit A+B+cin, one SEG_WIDTH-bit segment per clock,
// LSB segment first, with exact (chained carry) or approximate (cut carry) mode.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   bus      seg_serial_adder_if.slave (operand handshake in, result handshake out)
module seg_serial_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    seg_serial_adder_if.slave   bus
);
    localparam int NUM_SEG = WIDTH / SEG_WIDTH;
    localparam int KW      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             approx_q, approx_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic                 last;
    logic                 cin;
    logic [SEG_WIDTH:0]   seg_sum;

    // Operands are shifted right each RUN cycle so the active segment is always
    // the low SEG_WIDTH bits; no wide read mux is needed.
    assign last    = (k_q == KW'(NUM_SEG - 1));
    assign cin     = (k_q == '0 || !approx_q) ? c_q : 1'b0;
    assign seg_sum = {1'b0, a_q[SEG_WIDTH-1:0]} + {1'b0, b_q[SEG_WIDTH-1:0]}
                   + {{SEG_WIDTH{1'b0}}, cin};

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        approx_d = approx_q;
        c_d      = c_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    a_d      = bus.input1_i;
                    b_d      = bus.input2_i;
                    approx_d = bus.approx_i;
                    c_d      = bus.carry_i;
                    err_d    = 1'b0;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*SEG_WIDTH +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
                c_d   = seg_sum[SEG_WIDTH];
                a_d   = a_q >> SEG_WIDTH;
                b_d   = b_q >> SEG_WIDTH;
                // A carry out of any but the top segment is discarded in approx mode.
                err_d = err_q | (approx_q & seg_sum[SEG_WIDTH] & !last);
                if (last) begin
                    carry_d = seg_sum[SEG_WIDTH];
                    state_d = HOLD;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            c_q      <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            approx_q <= approx_d;
            c_q      <= c_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == HOLD);
    assign bus.sum_o       = sum_q;
    assign bus.carry_o     = carry_q;
    assign bus.err_o       = err_q;
endmodule
